// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the sequential Booth multiplier
package mul_pkg;

    localparam int DEFAULT_WIDTH = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'b00,
        BOOTH_ADD = 2'b01,
        BOOTH_SUB = 2'b10
    } booth_op_e;

    // {P[0], q}: 01 means a run of ones just ended (add), 10 means one started (subtract)
    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        case (pair)
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth step: add/sub into the high half, then arithmetic shift
module booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] p_in,
    input  logic               q_in,
    input  logic [WIDTH-1:0]   a_in,
    output logic [2*WIDTH-1:0] p_out,
    output logic               q_out
);

    booth_op_e      op;
    logic [WIDTH:0] hi_ext;
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] sum;

    // One extra bit keeps the sign right when A is the most-negative value
    always_comb begin
        hi_ext = {p_in[2*WIDTH-1], p_in[2*WIDTH-1:WIDTH]};
        a_ext  = {a_in[WIDTH-1], a_in};
        op     = booth_decode({p_in[0], q_in});
        sum    = hi_ext;
        case (op)
            BOOTH_ADD: sum = hi_ext + a_ext;
            BOOTH_SUB: sum = hi_ext - a_ext;
            default:   sum = hi_ext;
        endcase
    end

    assign p_out = {sum, p_in[WIDTH-1:1]};
    assign q_out = p_in[0];

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multi-cycle signed multiplier controller; MUL_ZERO_BYPASS_EN skips steps for zero operands
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               q_q, q_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] p_step;
    logic               q_step;

    booth_step #(.WIDTH(WIDTH)) u_booth_step (
        .p_in  (p_q),
        .q_in  (q_q),
        .a_in  (a_q),
        .p_out (p_step),
        .q_out (q_step)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        q_d     = q_q;
        count_d = count_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = multiplicand;
                    p_d     = {{WIDTH{1'b0}}, multiplier};
                    q_d     = 1'b0;
                    count_d = '0;
                    state_d = S_STEP;
`ifdef MUL_ZERO_BYPASS_EN
                    if (multiplicand == '0 || multiplier == '0) begin
                        prod_d  = '0;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_STEP: begin
                p_d     = p_step;
                q_d     = q_step;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    prod_d  = p_step;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            p_q     <= '0;
            q_q     <= 1'b0;
            count_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            q_q     <= q_d;
            count_q <= count_d;
            prod_q  <= prod_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = (state_q == S_STEP) || (state_q == S_DONE);
    assign done    = (state_q == S_DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - randomized and directed checks of mul_sequencer against a cycle-level product model
module tb_mul_sequencer;

    localparam int W = 32;
`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           clear_n;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           ready, busy, done;
    logic [2*W-1:0] product;

    int tests = 0;
    int errors = 0;

    mul_sequencer #(.WIDTH(W)) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Model: m_cnt is edges since acceptance plus one (0 = idle); done shows after m_len edges
    int          m_cnt = 0;
    int          m_len = W;
    logic [63:0] m_pend = '0;
    logic [63:0] m_prod = '0;

    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            m_cnt  = 0;
            m_prod = '0;
        end else begin
            if (m_cnt == 0) begin
                if (start) begin
                    longint sa, sb;
                    sa     = longint'($signed(multiplicand));
                    sb     = longint'($signed(multiplier));
                    m_pend = sa * sb;
                    m_len  = (BYP && (multiplicand == 0 || multiplier == 0)) ? 0 : W;
                    m_cnt  = 1;
                end
            end else if (m_cnt == m_len + 1) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            if (m_cnt != 0 && m_cnt == m_len + 1) m_prod = m_pend;
        end
    end

    always @(negedge clock) begin
        check("ready",   64'(ready), 64'(m_cnt == 0));
        check("busy",    64'(busy),  64'(m_cnt != 0));
        check("done",    64'(done),  64'(m_cnt != 0 && m_cnt == m_len + 1));
        check("product", product,    m_prod);
    end

    // Called just after the accepting edge (or later, with remaining latency); returns at idle, #1 after an edge
    task automatic wait_done(input string name, input logic [63:0] exp, input int lat);
        int k = 0;
        @(negedge clock);
        while (!done && k < 40) begin
            @(posedge clock);
            k++;
            @(negedge clock);
        end
        check({name, " done seen"}, 64'(done), 64'(1));
        check({name, " latency"}, 64'(k), 64'(lat));
        check({name, " product"}, product, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clock);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        wait_done(name, exp, (BYP && (a == 0 || b == 0)) ? 0 : W);
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return W'($signed($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nd;
        clear_n      = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset ready",   64'(ready), 64'(1));
        check("reset busy",    64'(busy),  64'(0));
        check("reset done",    64'(done),  64'(0));
        check("reset product", product,    64'h0);
        clear_n = 1'b1;
        @(posedge clock);
        #1;

        run_op("6x7",     32'd6,          32'd7,          64'h0000_0000_0000_002A);
        run_op("-3x5",    32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1);
        run_op("min*min", 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("min*1",   32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000);
        run_op("0x1234",  32'd0,          32'h1234,       64'h0);

        // start during STEP is ignored; held start gives the next op once back in IDLE
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        start        = 1'b1;
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        wait_done("9x9", 64'h51, W - 10);
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done("2x2 held", 64'h4, W);

        // abort mid-op
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        start        = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (16) @(posedge clock);
        #2;
        clear_n = 1'b0;
        #1;
        check("abort ready",   64'(ready), 64'(1));
        check("abort busy",    64'(busy),  64'(0));
        check("abort done",    64'(done),  64'(0));
        check("abort product", product,    64'h0);
        @(posedge clock);
        #1;
        clear_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) nd++;
        end
        check("abort no done", 64'(nd), 64'(0));
        @(posedge clock);
        #1;
        run_op("3x3", 32'd3, 32'd3, 64'h9);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clock);
            #1;
            start        = ($urandom_range(0, 3) == 0);
            multiplicand = rnd_operand();
            multiplier   = rnd_operand();
        end
        start = 1'b0;
        repeat (40) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
